// File: rtl/bu_pkg.sv
// Branch unit shared definitions: BrOp encodings, BHT counter type,
// reset value and the saturating counter step.
package bu_pkg;

  localparam logic [4:0] BR_NONE = 5'b00000;
  localparam logic [4:0] BR_EQ   = 5'b01000;
  localparam logic [4:0] BR_NE   = 5'b01001;
  localparam logic [4:0] BR_LT   = 5'b01100;
  localparam logic [4:0] BR_GE   = 5'b01101;
  localparam logic [4:0] BR_LTU  = 5'b01110;
  localparam logic [4:0] BR_GEU  = 5'b01111;
  localparam logic [4:0] BR_JUMP = 5'b10000;

  typedef logic [1:0] bht_ctr_t;

  localparam bht_ctr_t BHT_RESET = 2'b01;

  function automatic bht_ctr_t ctr_next(
    input bht_ctr_t c,
    input logic     taken
  );
    bht_ctr_t n;
    n = c;
    if (taken) begin
      if (c != 2'b11) n = c + 2'b01;
    end else begin
      if (c != 2'b00) n = c - 2'b01;
    end
    return n;
  endfunction

endpackage

// File: rtl/bu_if.sv
// IF/EX bundle of the branch unit; master = pipeline, slave = predictor.
// Stats signals exist only when BU_STATS_EN is defined.
interface bu_if #(
  parameter int XLEN = 32
);
  logic [XLEN-1:0] Pc_if;
  logic            PredTaken_if;
  logic            Valid_ex;
  logic            Stall_ex;
  logic [XLEN-1:0] Pc_ex;
  logic [XLEN-1:0] A;
  logic [XLEN-1:0] B;
  logic [4:0]      BrOp_ex;
  logic            PredTaken_ex;
  logic            NextPcSrc;
  logic            Redirect;
  logic            RedirectSeq;
`ifdef BU_STATS_EN
  logic [31:0]     BrCount;
  logic [31:0]     MissCount;

  modport master (
    output Pc_if, Valid_ex, Stall_ex, Pc_ex,
    output A, B, BrOp_ex, PredTaken_ex,
    input  PredTaken_if, NextPcSrc,
    input  Redirect, RedirectSeq,
    input  BrCount, MissCount
  );

  modport slave (
    input  Pc_if, Valid_ex, Stall_ex, Pc_ex,
    input  A, B, BrOp_ex, PredTaken_ex,
    output PredTaken_if, NextPcSrc,
    output Redirect, RedirectSeq,
    output BrCount, MissCount
  );
`else
  modport master (
    output Pc_if, Valid_ex, Stall_ex, Pc_ex,
    output A, B, BrOp_ex, PredTaken_ex,
    input  PredTaken_if, NextPcSrc,
    input  Redirect, RedirectSeq
  );

  modport slave (
    input  Pc_if, Valid_ex, Stall_ex, Pc_ex,
    input  A, B, BrOp_ex, PredTaken_ex,
    output PredTaken_if, NextPcSrc,
    output Redirect, RedirectSeq
  );
`endif
endinterface

// File: rtl/bu_cmp.sv
// Combinational branch comparator: A, B, BrOp_ex -> NextPcSrc.
// Jumps always take; non-branches and ccc 010/011 never take.
module bu_cmp
  import bu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] A,
  input  logic [XLEN-1:0] B,
  input  logic [4:0]      BrOp_ex,
  output logic            NextPcSrc
);

  logic eq;
  logic lt_s;
  logic lt_u;
  logic cond;

  assign eq   = (A == B);
  assign lt_s = ($signed(A) < $signed(B));
  assign lt_u = (A < B);

  always_comb begin
    cond = 1'b0;
    case (BrOp_ex[2:0])
      3'b000:  cond = eq;
      3'b001:  cond = ~eq;
      3'b100:  cond = lt_s;
      3'b101:  cond = ~lt_s;
      3'b110:  cond = lt_u;
      3'b111:  cond = ~lt_u;
      default: cond = 1'b0;
    endcase
  end

  always_comb begin
    NextPcSrc = 1'b0;
    priority case (1'b1)
      BrOp_ex[4]:  NextPcSrc = 1'b1;
      !BrOp_ex[3]: NextPcSrc = 1'b0;
      default:     NextPcSrc = cond;
    endcase
  end

endmodule

// File: rtl/bu_predictor.sv
// Branch unit with 2-bit saturating BHT: IF prediction, EX resolve,
// redirect flags. Optional BrCount/MissCount under BU_STATS_EN.
module bu_predictor
  import bu_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int BHT_ENTRIES = 64,
  parameter int IDX_LSB     = 2
) (
  input  logic clk,
  input  logic rst_n,
  bu_if.slave  bus
);

  localparam int IDX_W = $clog2(BHT_ENTRIES);

  bht_ctr_t bht [BHT_ENTRIES];

  logic [IDX_W-1:0] idx_if;
  logic [IDX_W-1:0] idx_ex;
  logic             take_raw;
  logic             take;
  logic             is_cond;
  logic             is_jump;
  logic             upd;
  logic             redirect;
  logic             redirect_seq;
  logic             unused_ok;

  assign idx_if = bus.Pc_if[IDX_LSB +: IDX_W];
  assign idx_ex = bus.Pc_ex[IDX_LSB +: IDX_W];

  // Upper PC bits alias by design.
  assign unused_ok = ^{bus.Pc_if, bus.Pc_ex};

  bu_cmp #(
    .XLEN (XLEN)
  ) u_cmp (
    .A         (bus.A),
    .B         (bus.B),
    .BrOp_ex   (bus.BrOp_ex),
    .NextPcSrc (take_raw)
  );

  assign is_jump = bus.BrOp_ex[4];
  assign is_cond = (bus.BrOp_ex[4:3] == 2'b01);
  assign take    = bus.Valid_ex & take_raw;

  always_comb begin
    redirect     = 1'b0;
    redirect_seq = 1'b0;
    if (bus.Valid_ex) begin
      if (is_jump) begin
        redirect = ~bus.PredTaken_ex;
      end else if (is_cond) begin
        redirect     = take ^ bus.PredTaken_ex;
        redirect_seq = ~take;
      end
    end
  end

  assign upd = bus.Valid_ex & ~bus.Stall_ex & is_cond;

  // No bypass: IF reads the pre-update value on an index collision.
  assign bus.PredTaken_if = bht[idx_if][1];
  assign bus.NextPcSrc    = take;
  assign bus.Redirect     = redirect;
  assign bus.RedirectSeq  = redirect_seq;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < BHT_ENTRIES; i++) begin
        bht[i] <= BHT_RESET;
      end
    end else if (upd) begin
      bht[idx_ex] <= ctr_next(bht[idx_ex], take);
    end
  end

`ifdef BU_STATS_EN
  logic [31:0] br_cnt;
  logic [31:0] miss_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      br_cnt   <= '0;
      miss_cnt <= '0;
    end else if (upd) begin
      br_cnt <= br_cnt + 32'd1;
      if (redirect) miss_cnt <= miss_cnt + 32'd1;
    end
  end

  assign bus.BrCount   = br_cnt;
  assign bus.MissCount = miss_cnt;
`endif

endmodule
